// File: rtl/ftsd_pkg.sv
// ftsd_pkg: shared constants, scan states and hex-to-segment table for the seven-segment scanner
package ftsd_pkg;

    localparam logic [7:0] SEG_OFF = 8'hFF;

    typedef enum logic {ST_BLANK, ST_SHOW} scan_state_t;

    // Active-low {dp,g,f,e,d,c,b,a} with dp off
    function automatic logic [7:0] hex_to_seg(input logic [3:0] hex);
        case (hex)
            4'h0: hex_to_seg = 8'hC0;
            4'h1: hex_to_seg = 8'hF9;
            4'h2: hex_to_seg = 8'hA4;
            4'h3: hex_to_seg = 8'hB0;
            4'h4: hex_to_seg = 8'h99;
            4'h5: hex_to_seg = 8'h92;
            4'h6: hex_to_seg = 8'h82;
            4'h7: hex_to_seg = 8'hF8;
            4'h8: hex_to_seg = 8'h80;
            4'h9: hex_to_seg = 8'h90;
            4'hA: hex_to_seg = 8'h88;
            4'hB: hex_to_seg = 8'h83;
            4'hC: hex_to_seg = 8'hC6;
            4'hD: hex_to_seg = 8'hA1;
            4'hE: hex_to_seg = 8'h86;
            4'hF: hex_to_seg = 8'h8E;
        endcase
    endfunction

endpackage

// File: rtl/ftsd_hex_decoder.sv
// ftsd_hex_decoder: combinational hex/dp/dark to active-low segment pattern
module ftsd_hex_decoder
    import ftsd_pkg::*;
(
    input  logic [3:0] hex,
    input  logic       dp,
    input  logic       dark,
    output logic [7:0] seg
);

    assign seg = dark ? SEG_OFF : (hex_to_seg(hex) & {~dp, 7'h7F});

endmodule

// File: rtl/ftsd_scan_ctl.sv
// ftsd_scan_ctl: multiplexes hex digits onto a shared segment bus with a blanking gap between digits
module ftsd_scan_ctl
    import ftsd_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int SCAN_SEL_W   = 2,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    scan_tick_in,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blank_in,
    input  logic                    lz_blank_en,
    output logic [7:0]              seg_out,
    output logic [NUM_DIGITS-1:0]   dig_en,
    output logic [SCAN_SEL_W-1:0]   scan_idx
);

    localparam int CNT_W = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_START = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [SCAN_SEL_W-1:0] LAST_IDX = SCAN_SEL_W'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] DIG_ONE = NUM_DIGITS'(1);

    logic                  sync1, sync2, hist, advance, above_zero;
    scan_state_t           state, state_nxt;
    logic [CNT_W-1:0]      blank_cnt, cnt_nxt;
    logic [SCAN_SEL_W-1:0] idx_nxt;
    logic [7:0]            seg_nxt, seg_dec;
    logic [NUM_DIGITS-1:0] en_nxt, lz;

    assign advance = sync2 & ~hist;

    // A digit is a leading zero when it and every digit above it are zero
    always_comb begin
        above_zero = 1'b1;
        lz = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            above_zero = above_zero & (digits_in[4*i +: 4] == 4'h0);
            lz[i] = lz_blank_en & above_zero & (i != 0);
        end
    end

    ftsd_hex_decoder u_dec (
        .hex  (digits_in[4*scan_idx +: 4]),
        .dp   (dp_in[scan_idx]),
        .dark (blank_in[scan_idx] | lz[scan_idx]),
        .seg  (seg_dec)
    );

    always_comb begin
        state_nxt = state;
        cnt_nxt   = blank_cnt;
        idx_nxt   = scan_idx;
        seg_nxt   = seg_out;
        en_nxt    = dig_en;
        if (state == ST_BLANK) begin
            cnt_nxt = (blank_cnt == '0) ? blank_cnt : blank_cnt - CNT_W'(1);
            if (blank_cnt == '0) begin
                state_nxt = ST_SHOW;
                seg_nxt   = seg_dec;
                en_nxt    = ~(DIG_ONE << scan_idx);
            end
        end else if (advance) begin
            state_nxt = ST_BLANK;
            cnt_nxt   = CNT_START;
            idx_nxt   = (scan_idx == LAST_IDX) ? '0 : scan_idx + SCAN_SEL_W'(1);
            seg_nxt   = SEG_OFF;
            en_nxt    = '1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1     <= 1'b0;
            sync2     <= 1'b0;
            hist      <= 1'b0;
            state     <= ST_BLANK;
            blank_cnt <= CNT_START;
            scan_idx  <= '0;
            seg_out   <= SEG_OFF;
            dig_en    <= '1;
        end else begin
            sync1     <= scan_tick_in;
            sync2     <= sync1;
            hist      <= sync2;
            state     <= state_nxt;
            blank_cnt <= cnt_nxt;
            scan_idx  <= idx_nxt;
            seg_out   <= seg_nxt;
            dig_en    <= en_nxt;
        end
    end

endmodule
